alu_operand_stage: RTL

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// ALU operand stage: one-entry pipeline register that selects and registers ALU operands.
// Optional writeback bypass on the rs/rt operands is enabled by defining ALU_OPERAND_FWD_EN.
module alu_operand_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 22,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         opcode,
  input  logic [3:0]         fcode,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  input  logic [4:0]         rs_idx,
  input  logic [4:0]         rt_idx,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [IMM_W-1:0]   imm,
  input  logic               flush,
  input  logic               fwd_valid,
  input  logic [4:0]         fwd_idx,
  input  logic [DATA_W-1:0]  fwd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  alu_inp1,
  output logic [DATA_W-1:0]  alu_inp2,
  output logic [2:0]         out_opcode,
  output logic [3:0]         out_fcode,
  output logic [15:0]        stall_cnt
);

  localparam int unsigned EXT_W   = DATA_W - IMM_W;
  localparam logic [2:0]  OP_REG  = 3'd0;
  localparam logic [2:0]  OP_IMM  = 3'd1;
  localparam logic [3:0]  FC_SLL  = 4'd4;
  localparam logic [3:0]  FC_SRL  = 4'd5;
  localparam logic [3:0]  FC_SRA  = 4'd8;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic              r_valid;
  logic [DATA_W-1:0] r_inp1;
  logic [DATA_W-1:0] r_inp2;
  logic [2:0]        r_opcode;
  logic [3:0]        r_fcode;
  logic [15:0]       r_stall_cnt;

  logic              w_valid_nxt;
  logic [DATA_W-1:0] w_inp1_nxt;
  logic [DATA_W-1:0] w_inp2_nxt;
  logic [2:0]        w_opcode_nxt;
  logic [3:0]        w_fcode_nxt;
  logic [15:0]       w_stall_cnt_nxt;

  logic              w_in_ready;
  logic              w_capture;
  logic              w_stalled;
  logic [DATA_W-1:0] w_rs_opnd;
  logic [DATA_W-1:0] w_rt_opnd;
  logic [DATA_W-1:0] w_sel_inp1;
  logic [DATA_W-1:0] w_sel_inp2;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_shamt_zext;

  assign w_in_ready = !r_valid || out_ready;
  assign w_capture  = in_valid && w_in_ready && !flush;
  assign w_stalled  = r_valid && !out_ready;

`ifdef ALU_OPERAND_FWD_EN
  // Writeback bypass; register 0 is never forwarded.
  assign w_rs_opnd = (fwd_valid && (fwd_idx == rs_idx) && (rs_idx != 5'd0)) ? fwd_data : rs_data;
  assign w_rt_opnd = (fwd_valid && (fwd_idx == rt_idx) && (rt_idx != 5'd0)) ? fwd_data : rt_data;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_valid, fwd_idx, fwd_data, rs_idx, rt_idx};
  assign w_rs_opnd    = rs_data;
  assign w_rt_opnd    = rt_data;
`endif

  assign w_imm_sext   = {{EXT_W{imm[IMM_W-1]}}, imm};
  assign w_shamt_zext = DATA_W'(shamt);

  // Operand selection by instruction class.
  always_comb begin
    w_sel_inp1 = '0;
    w_sel_inp2 = '0;
    case (opcode)
      OP_REG: begin
        w_sel_inp1 = w_rs_opnd;
        if ((fcode == FC_SLL) || (fcode == FC_SRL) || (fcode == FC_SRA)) begin
          w_sel_inp2 = w_shamt_zext;
        end else begin
          w_sel_inp2 = w_rt_opnd;
        end
      end
      OP_IMM: begin
        w_sel_inp1 = w_rs_opnd;
        w_sel_inp2 = w_imm_sext;
      end
      default: begin
        w_sel_inp1 = '0;
        w_sel_inp2 = '0;
      end
    endcase
  end

  // Next-state: flush beats capture, capture beats drain, otherwise hold.
  always_comb begin
    w_valid_nxt     = r_valid;
    w_inp1_nxt      = r_inp1;
    w_inp2_nxt      = r_inp2;
    w_opcode_nxt    = r_opcode;
    w_fcode_nxt     = r_fcode;
    w_stall_cnt_nxt = r_stall_cnt;
    if (w_stalled && (r_stall_cnt != CNT_MAX)) begin
      w_stall_cnt_nxt = r_stall_cnt + 16'd1;
    end
    if (flush) begin
      w_valid_nxt = 1'b0;
    end else if (w_capture) begin
      w_valid_nxt  = 1'b1;
      w_inp1_nxt   = w_sel_inp1;
      w_inp2_nxt   = w_sel_inp2;
      w_opcode_nxt = opcode;
      w_fcode_nxt  = fcode;
    end else if (out_ready) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_inp1      <= '0;
      r_inp2      <= '0;
      r_opcode    <= '0;
      r_fcode     <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_valid     <= w_valid_nxt;
      r_inp1      <= w_inp1_nxt;
      r_inp2      <= w_inp2_nxt;
      r_opcode    <= w_opcode_nxt;
      r_fcode     <= w_fcode_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_valid;
  assign alu_inp1   = r_inp1;
  assign alu_inp2   = r_inp2;
  assign out_opcode = r_opcode;
  assign out_fcode  = r_fcode;
  assign stall_cnt  = r_stall_cnt;

endmodule
